// File: rtl/store_trk_pkg.sv
// Shared types and constants for the store issue/outstanding tracker.
package store_trk_pkg;

    typedef enum logic {ST_RUN, ST_DRAIN} trk_state_t;

    localparam int DRAIN_CNT_W = 16;

endpackage

// File: rtl/store_popcnt.sv
// Population count of a small valid mask; used for the issue and retire masks.
module store_popcnt #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 2
) (
    input  logic [IN_W-1:0]  bits_i,
    output logic [OUT_W-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < IN_W; i++) begin
            count_o = count_o + OUT_W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/store_exe_tracker.sv
// Store issue counter, saturating outstanding-store tracker and drain FSM.
// Optional drain-cycle performance counter enabled by STORE_TRK_PERF_EN.
//
//   state    | meaning
//   ST_RUN   | stores from the AGU ports are accepted and counted
//   ST_DRAIN | issue stalled until outstanding stores reach zero
module store_exe_tracker
    import store_trk_pkg::*;
#(
    parameter int CNT_W     = 5,
    parameter int ISS_PORTS = 2,
    parameter int RET_PORTS = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ISS_PORTS-1:0]   agu_iss,
    input  logic [ISS_PORTS-1:0]   agu_ctrl_3,
    input  logic [RET_PORTS-1:0]   store_ret,
    input  logic                   flush,
    input  logic                   drain_req,
    output logic [CNT_W-1:0]       store_exe_num,
    output logic [CNT_W-1:0]       store_pend_num,
    output logic                   pend_empty,
    output logic                   pend_full,
    output logic                   iss_stall,
    output logic                   drain_done,
    output logic                   err_overflow,
    output logic                   err_underflow,
    output logic [DRAIN_CNT_W-1:0] drain_cycles
);

    localparam int ISS_W = $clog2(ISS_PORTS + 1);
    localparam int RET_W = $clog2(RET_PORTS + 1);
    localparam int SUM_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    trk_state_t        state_q;
    logic [CNT_W-1:0]  exe_q, pend_q, pend_d;
    logic              drain_done_q, err_of_q, err_uf_q;
    logic              set_of, set_uf;
    logic [ISS_W-1:0]  iss_cnt, iss_acc;
    logic [RET_W-1:0]  ret_cnt;
    logic signed [SUM_W-1:0] sum;

    store_popcnt #(.IN_W(ISS_PORTS), .OUT_W(ISS_W)) u_iss_cnt (
        .bits_i  (agu_iss & agu_ctrl_3),
        .count_o (iss_cnt)
    );

    store_popcnt #(.IN_W(RET_PORTS), .OUT_W(RET_W)) u_ret_cnt (
        .bits_i  (store_ret),
        .count_o (ret_cnt)
    );

    assign iss_acc = (state_q == ST_RUN) ? iss_cnt : '0;

    // Issue and retire are netted first, then the result is clamped.
    always_comb begin
        sum    = $signed(SUM_W'(pend_q)) + $signed(SUM_W'(iss_acc))
               - $signed(SUM_W'(ret_cnt));
        pend_d = sum[CNT_W-1:0];
        set_of = 1'b0;
        set_uf = 1'b0;
        if (sum < 0) begin
            pend_d = '0;
            set_uf = 1'b1;
        end else if (sum > $signed(SUM_W'(PEND_MAX))) begin
            pend_d = PEND_MAX;
            set_of = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            exe_q        <= '0;
            pend_q       <= '0;
            drain_done_q <= 1'b0;
            err_of_q     <= 1'b0;
            err_uf_q     <= 1'b0;
        end else begin
            exe_q        <= exe_q + CNT_W'(iss_acc);
            drain_done_q <= 1'b0;
            if (flush) begin
                pend_q  <= '0;
                state_q <= ST_RUN;
            end else begin
                pend_q   <= pend_d;
                err_of_q <= err_of_q | set_of;
                err_uf_q <= err_uf_q | set_uf;
                case (state_q)
                    ST_RUN: begin
                        if (drain_req) state_q <= ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        if (pend_d == '0) begin
                            state_q      <= ST_RUN;
                            drain_done_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_RUN;
                endcase
            end
        end
    end

`ifdef STORE_TRK_PERF_EN
    logic [DRAIN_CNT_W-1:0] drain_cyc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cyc_q <= '0;
        end else if (state_q == ST_DRAIN && drain_cyc_q != '1) begin
            drain_cyc_q <= drain_cyc_q + 1'b1;
        end
    end

    assign drain_cycles = drain_cyc_q;
`else
    assign drain_cycles = '0;
`endif

    assign store_exe_num  = exe_q;
    assign store_pend_num = pend_q;
    assign pend_empty     = (pend_q == '0);
    assign pend_full      = (pend_q == PEND_MAX);
    assign iss_stall      = (state_q == ST_DRAIN);
    assign drain_done     = drain_done_q;
    assign err_overflow   = err_of_q;
    assign err_underflow  = err_uf_q;

endmodule

// File: tb/tb_store_exe_tracker.sv
// Directed self-checking bench for store_exe_tracker (CNT_W=5, 2 issue, 1 retire port).
module tb_store_exe_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  agu_iss, agu_ctrl_3;
    logic [0:0]  store_ret;
    logic        flush, drain_req;
    logic [4:0]  store_exe_num, store_pend_num;
    logic        pend_empty, pend_full, iss_stall, drain_done;
    logic        err_overflow, err_underflow;
    logic [15:0] drain_cycles;

    int n_checks = 0;
    int n_errors = 0;

    store_exe_tracker #(.CNT_W(5), .ISS_PORTS(2), .RET_PORTS(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .agu_iss        (agu_iss),
        .agu_ctrl_3     (agu_ctrl_3),
        .store_ret      (store_ret),
        .flush          (flush),
        .drain_req      (drain_req),
        .store_exe_num  (store_exe_num),
        .store_pend_num (store_pend_num),
        .pend_empty     (pend_empty),
        .pend_full      (pend_full),
        .iss_stall      (iss_stall),
        .drain_done     (drain_done),
        .err_overflow   (err_overflow),
        .err_underflow  (err_underflow),
        .drain_cycles   (drain_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply current inputs for one clock, then sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        agu_iss = 2'b00; agu_ctrl_3 = 2'b00; store_ret = 1'b0;
        flush = 1'b0; drain_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic issue(input logic [1:0] iss, input logic [1:0] ctl);
        agu_iss = iss; agu_ctrl_3 = ctl;
        tick();
        idle_in();
    endtask

    initial begin
        idle_in();
        reset = 1'b0;

        // Reset
        do_reset();
        check_val("rst_exe", store_exe_num, 0);
        check_val("rst_pend", store_pend_num, 0);
        check_val("rst_empty", pend_empty, 1);
        check_val("rst_full", pend_full, 0);
        check_val("rst_stall", iss_stall, 0);
        check_val("rst_done", drain_done, 0);
        check_val("rst_of", err_overflow, 0);
        check_val("rst_uf", err_underflow, 0);
        check_val("rst_dcyc", drain_cycles, 0);

        // Masking by store flag
        issue(2'b11, 2'b01);
        check_val("mask_exe", store_exe_num, 1);
        check_val("mask_pend", store_pend_num, 1);
        check_val("mask_empty", pend_empty, 0);

        // Wrap and saturation
        do_reset();
        agu_iss = 2'b11; agu_ctrl_3 = 2'b11;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c == 15) begin
                check_val("sat_c15_pend", store_pend_num, 30);
                check_val("sat_c15_full", pend_full, 0);
                check_val("sat_c15_of", err_overflow, 0);
            end
            if (c == 16) begin
                check_val("sat_c16_pend", store_pend_num, 31);
                check_val("sat_c16_full", pend_full, 1);
                check_val("sat_c16_of", err_overflow, 1);
            end
        end
        idle_in();
        check_val("wrap_exe", store_exe_num, 2);
        check_val("sat_c17_pend", store_pend_num, 31);

        // Netting then underflow
        do_reset();
        agu_iss = 2'b01; agu_ctrl_3 = 2'b01; store_ret = 1'b1;
        tick();
        idle_in();
        check_val("net_pend", store_pend_num, 0);
        check_val("net_exe", store_exe_num, 1);
        check_val("net_uf", err_underflow, 0);
        store_ret = 1'b1;
        tick();
        idle_in();
        check_val("uf_pend", store_pend_num, 0);
        check_val("uf_flag", err_underflow, 1);
        tick();
        check_val("uf_sticky", err_underflow, 1);

        // Drain from pend=3
        do_reset();
        issue(2'b11, 2'b11);
        issue(2'b01, 2'b11);
        check_val("drn_pre_pend", store_pend_num, 3);
        drain_req = 1'b1;
        tick();
        idle_in();
        check_val("drn_stall", iss_stall, 1);
        check_val("drn_a_pend", store_pend_num, 3);
        check_val("drn_a_done", drain_done, 0);
        agu_iss = 2'b11; agu_ctrl_3 = 2'b11; store_ret = 1'b1;
        for (int p = 2; p >= 0; p--) begin
            tick();
            check_val("drn_pend", store_pend_num, p);
            check_val("drn_exe", store_exe_num, 3);
            check_val("drn_done", drain_done, (p == 0) ? 1 : 0);
            check_val("drn_stall_d", iss_stall, (p == 0) ? 0 : 1);
        end
        idle_in();
        tick();
        check_val("drn_done_pulse", drain_done, 0);
`ifdef STORE_TRK_PERF_EN
        check_val("drn_dcyc", drain_cycles, 3);
`else
        check_val("drn_dcyc", drain_cycles, 0);
`endif

        // Drain entered with nothing outstanding
        drain_req = 1'b1;
        tick();
        idle_in();
        check_val("drn0_stall", iss_stall, 1);
        check_val("drn0_done0", drain_done, 0);
        tick();
        check_val("drn0_exit", iss_stall, 0);
        check_val("drn0_done1", drain_done, 1);

        // Flush mid-drain
        do_reset();
        issue(2'b11, 2'b11);
        issue(2'b11, 2'b11);
        issue(2'b10, 2'b10);
        check_val("fl_pre_pend", store_pend_num, 5);
        drain_req = 1'b1;
        tick();
        agu_iss = 2'b11; agu_ctrl_3 = 2'b11; drain_req = 1'b1;
        tick();
        check_val("fl_drn_pend", store_pend_num, 5);
        check_val("fl_drn_stall", iss_stall, 1);
        flush = 1'b1; store_ret = 1'b1;
        tick();
        idle_in();
        check_val("fl_pend", store_pend_num, 0);
        check_val("fl_stall", iss_stall, 0);
        check_val("fl_done", drain_done, 0);
        check_val("fl_exe", store_exe_num, 5);
        check_val("fl_uf", err_underflow, 0);
        tick();
`ifdef STORE_TRK_PERF_EN
        check_val("fl_dcyc", drain_cycles, 2);
`else
        check_val("fl_dcyc", drain_cycles, 0);
`endif

        // Flush in RUN still counts the issues
        agu_iss = 2'b11; agu_ctrl_3 = 2'b11; flush = 1'b1;
        tick();
        idle_in();
        check_val("flrun_exe", store_exe_num, 7);
        check_val("flrun_pend", store_pend_num, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/store_exe_tracker.md
Name: store_exe_tracker

Overview:
- Parametrised successor to the single-port store-issue counter.
- Counts stores issued from N AGU ports into a wrapping total.
- Tracks outstanding (issued but not retired) stores in a saturating occupancy counter with sticky error flags.
- Provides a drain FSM that stalls further store issue until all outstanding stores retire; sits between AGU issue and the store-retire path of the LSU.

Parameters:
- CNT_W, 5, width of total and outstanding counters; PEND_MAX = 2^CNT_W-1.
- ISS_PORTS, 2, number of AGU issue ports.
- RET_PORTS, 1, number of store-retire ports.

Ports:
- clk  in  1  clock, single domain.
- reset  in  1  synchronous, active-high reset.
- agu_iss  in  ISS_PORTS  per-port issue valid.
- agu_ctrl_3  in  ISS_PORTS  per-port "op is store" flag.
- store_ret  in  RET_PORTS  per-port store-retire pulse.
- flush  in  1  pipeline flush; clears outstanding count.
- drain_req  in  1  single-cycle request to drain outstanding stores.
- store_exe_num  out  CNT_W  total stores issued, mod 2^CNT_W.
- store_pend_num  out  CNT_W  outstanding stores, saturating.
- pend_empty  out  1  store_pend_num==0 (combinational from register).
- pend_full  out  1  store_pend_num==PEND_MAX.
- iss_stall  out  1  high while in DRAIN; upstream must hold stores.
- drain_done  out  1  one-cycle pulse when a drain completes.
- err_overflow  out  1  sticky: increment clamped at PEND_MAX.
- err_underflow  out  1  sticky: retire clamped at 0.
- drain_cycles  out  16  cycles spent in DRAIN (optional feature).

Behaviour:
- Reset (clk edge with reset=1): all counters, flags and drain_cycles = 0; state RUN; drain_done = 0. Reset overrides everything.
- iss_acc = popcount(agu_iss & agu_ctrl_3) in RUN; forced to 0 in DRAIN, so stores presented in DRAIN are ignored.
- ret_cnt = popcount(store_ret).
- store_exe_num <= store_exe_num + iss_acc, wrapping mod 2^CNT_W. Not affected by flush.
- Outstanding update: sum = pend + iss_acc - ret_cnt, computed at CNT_W+2 signed width.
  - sum < 0: pend <= 0 and err_underflow <= 1.
  - sum > PEND_MAX: pend <= PEND_MAX and err_overflow <= 1.
  - Otherwise pend <= sum.
  - Simultaneous issue and retire in the same cycle is netted before clamping.
- Error flags are sticky and cleared only by reset.
- All outputs are registered; one-cycle latency from input to counter outputs.
- FSM states are RUN and DRAIN:
  - RUN: drain_req=1 -> DRAIN. Issues in that same cycle are still counted.
  - DRAIN: if next pend == 0, go to RUN and drain_done <= 1 for the next cycle only. Otherwise stay in DRAIN.
  - DRAIN entered with pend already 0 exits after one cycle in DRAIN.
  - drain_req while in DRAIN is ignored.
- iss_stall = (state == DRAIN).
- flush (priority below reset, above all else):
  - pend <= 0, state <= RUN, drain_done <= 0.
  - Issues and retires in the flush cycle are discarded for pend but counted into store_exe_num if state was RUN.

Optional Feature:
- Macro: STORE_TRK_PERF_EN.
- Defined:
  - drain_cycles increments each cycle the state is DRAIN.
  - Saturates at 16'hFFFF.
  - Cleared only by reset; flush does not clear it.
- Undefined: drain_cycles is tied to 16'h0 and no counter logic is present. The port is kept in both builds.

Decomposition:
- Package store_trk_pkg:
  - typedef enum logic {ST_RUN, ST_DRAIN} trk_state_t.
  - localparam DRAIN_CNT_W = 16.
- Sub-module store_popcnt, parametrised by input width and output width. Instantiated twice: issue mask and retire mask.

Test Plan (CNT_W=5, ISS_PORTS=2, RET_PORTS=1):
- Reset: hold reset 2 cycles -> all outputs 0, pend_empty=1, iss_stall=0.
- Masking: agu_iss=2'b11, agu_ctrl_3=2'b01 for 1 cycle -> store_exe_num=1, store_pend_num=1.
- Wrap and saturation: agu_iss=agu_ctrl_3=2'b11, no retire, 17 cycles:
  - store_exe_num=2 (34 mod 32).
  - After cycle 15, pend=30.
  - Cycle 16 clamps pend to 31, pend_full=1, err_overflow=1.
- Underflow: pend=0, store_ret=1 for 1 cycle -> pend stays 0, err_underflow=1 and remains set.
- Drain: pend=3, pulse drain_req, hold stores on both ports, store_ret=1 each cycle:
  - iss_stall=1 and store_exe_num frozen.
  - pend goes 3→2→1→0.
  - drain_done=1 for exactly the cycle pend reads 0, with iss_stall=0 in that cycle.
- Flush mid-drain: in DRAIN with pend=5, assert flush 1 cycle -> next cycle pend=0, state RUN, iss_stall=0, drain_done=0, store_exe_num unchanged; with STORE_TRK_PERF_EN, drain_cycles holds its value.
